// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: IR field positions,
// opcode values, state encodings and the opcode classifier.
package cpu_ctrl_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam int IDX_W  = 4;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_HALT = 5'd26;

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T1W  = 4'd3;
    localparam logic [3:0] S_T2   = 4'd4;
    localparam logic [3:0] S_T3   = 4'd5;
    localparam logic [3:0] S_T4   = 4'd6;
    localparam logic [3:0] S_T5   = 4'd7;
    localparam logic [3:0] S_T6   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_BINARY  = 3'd1,
        CLS_MULDIV  = 3'd2,
        CLS_UNARY   = 3'd3,
        CLS_HALT    = 3'd4
    } op_class_e;

    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   cls = CLS_BINARY;
            OP_MUL, OP_DIV:                    cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                    cls = CLS_UNARY;
            OP_HALT:                           cls = CLS_HALT;
            default:                           cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a register index plus enable into a one-hot general-register select;
// indices at or beyond NUM_REGS produce an all-zero vector.
module reg_select_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                 en,
    input  logic [IDX_W-1:0]     index,
    output logic [NUM_REGS-1:0]  onehot
);

    // One bit per register, set only when enabled and the index matches.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (int'(index) == i);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: walks fetch (T0-T2) and execute (T3-T6)
// and decodes every datapath strobe from the current state and IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] PC_INC_OP = 5'd12,
    parameter int         NUM_REGS  = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [31:0]          IR,
    input  logic                 mem_rdy,
    input  logic                 stall,
    output logic                 PCout,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 MDRout,
    output logic                 MARin,
    output logic                 PCin,
    output logic                 MDRin,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zin,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 Read,
    output logic [4:0]           OpCode,
    output logic [NUM_REGS-1:0]  Rin,
    output logic [NUM_REGS-1:0]  Rout,
    output logic                 run,
    output logic                 done
);

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [3:0]       out_state_s;
    logic [4:0]       op_s;
    logic [IDX_W-1:0] ra_s;
    logic [IDX_W-1:0] rb_s;
    logic [IDX_W-1:0] rc_s;
    op_class_e        cls_s;
    logic             rin_en_s;
    logic             rout_en_s;
    logic [IDX_W-1:0] rin_idx_s;
    logic [IDX_W-1:0] rout_idx_s;
    logic             unused_ir_s;

    assign op_s        = IR[OP_MSB:OP_LSB];
    assign ra_s        = IR[RA_MSB:RA_LSB];
    assign rb_s        = IR[RB_MSB:RB_LSB];
    assign rc_s        = IR[RC_MSB:RC_LSB];
    assign cls_s       = classify(op_s);
    assign unused_ir_s = ^IR[RC_LSB-1:0];

    // A stalled cycle decodes exactly like the idle reset state.
    assign out_state_s = stall ? S_RST : state_r;
    assign run         = (state_r != S_HALT);

    // State register; clr forces RST without waiting for a clock.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= S_RST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection; RST and HALT ignore stall.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_RST:  next_state_s = S_T0;
            S_HALT: next_state_s = S_HALT;
            default: begin
                if (stall) begin
                    next_state_s = state_r;
                end else begin
                    case (state_r)
                        S_T0:  next_state_s = S_T1;
                        S_T1,
                        S_T1W: next_state_s = mem_rdy ? S_T2 : S_T1W;
                        S_T2: begin
                            case (cls_s)
                                CLS_BINARY,
                                CLS_MULDIV,
                                CLS_UNARY: next_state_s = S_T3;
                                CLS_HALT:  next_state_s = S_HALT;
                                default:   next_state_s = S_T0;
                            endcase
                        end
                        S_T3: begin
                            case (cls_s)
                                CLS_BINARY,
                                CLS_MULDIV,
                                CLS_UNARY: next_state_s = S_T4;
                                default:   next_state_s = S_T0;
                            endcase
                        end
                        S_T4: begin
                            case (cls_s)
                                CLS_BINARY,
                                CLS_MULDIV: next_state_s = S_T5;
                                default:    next_state_s = S_T0;
                            endcase
                        end
                        S_T5: begin
                            case (cls_s)
                                CLS_MULDIV: next_state_s = S_T6;
                                default:    next_state_s = S_T0;
                            endcase
                        end
                        default: next_state_s = S_T0;
                    endcase
                end
            end
        endcase
    end

    // Output decode: every strobe defaults low, each state raises its own set.
    always_comb begin
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Read       = 1'b0;
        OpCode     = 5'd0;
        done       = 1'b0;
        rin_en_s   = 1'b0;
        rout_en_s  = 1'b0;
        rin_idx_s  = 4'd0;
        rout_idx_s = 4'd0;
        case (out_state_s)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                Zin    = 1'b1;
                OpCode = PC_INC_OP;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                done   = (cls_s == CLS_ILLEGAL);
            end
            S_T3: begin
                case (cls_s)
                    CLS_BINARY: begin
                        rout_en_s  = 1'b1;
                        rout_idx_s = rb_s;
                        Yin        = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en_s  = 1'b1;
                        rout_idx_s = ra_s;
                        Yin        = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en_s  = 1'b1;
                        rout_idx_s = rb_s;
                        Zin        = 1'b1;
                        OpCode     = op_s;
                    end
                    default: rout_en_s = 1'b0;
                endcase
            end
            S_T4: begin
                case (cls_s)
                    CLS_BINARY: begin
                        rout_en_s  = 1'b1;
                        rout_idx_s = rc_s;
                        Zin        = 1'b1;
                        OpCode     = op_s;
                    end
                    CLS_MULDIV: begin
                        rout_en_s  = 1'b1;
                        rout_idx_s = rb_s;
                        Zin        = 1'b1;
                        OpCode     = op_s;
                    end
                    CLS_UNARY: begin
                        Zlowout   = 1'b1;
                        rin_en_s  = 1'b1;
                        rin_idx_s = ra_s;
                        done      = 1'b1;
                    end
                    default: rout_en_s = 1'b0;
                endcase
            end
            S_T5: begin
                case (cls_s)
                    CLS_BINARY: begin
                        Zlowout   = 1'b1;
                        rin_en_s  = 1'b1;
                        rin_idx_s = ra_s;
                        done      = 1'b1;
                    end
                    CLS_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: rout_en_s = 1'b0;
                endcase
            end
            S_T6: begin
                if (cls_s == CLS_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                    done     = 1'b1;
                end else begin
                    done = 1'b0;
                end
            end
            default: done = 1'b0;
        endcase
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .en     (rin_en_s),
        .index  (rin_idx_s),
        .onehot (Rin)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .en     (rout_en_s),
        .index  (rout_idx_s),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-instruction reference model
// queues the expected output vector of every cycle; a negedge monitor compares.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        mem_rdy;
    logic        stall;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        Read, run, done;
    logic [4:0]  OpCode;
    logic [15:0] Rin, Rout;

    typedef struct packed {
        logic        pcout, zlowout, zhighout, mdrout;
        logic        marin, pcin, mdrin, irin, yin, zin, hiin, loin;
        logic        read;
        logic [4:0]  opcode;
        logic [15:0] rin;
        logic [15:0] rout;
        logic        run;
        logic        done;
    } vec_t;

    vec_t act;
    vec_t mon_e;
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .mem_rdy(mem_rdy), .stall(stall),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .Read(Read), .OpCode(OpCode),
        .Rin(Rin), .Rout(Rout), .run(run), .done(done)
    );

    assign act = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                  Yin, Zin, HIin, LOin, Read, OpCode, Rin, Rout, run, done};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h expected=%h", $time, act, mon_e);
            end
        end
    end

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        v.run = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] one;
        one = 16'h0001;
        return one << i;
    endfunction

    // 1 binary, 2 mul/div, 3 unary, 4 halt, 0 illegal
    function automatic int op_kind(input logic [4:0] op);
        if (op inside {[5'd3:5'd11]}) return 1;
        else if (op == 5'd15 || op == 5'd16) return 2;
        else if (op == 5'd17 || op == 5'd18) return 3;
        else if (op == 5'd26) return 4;
        else return 0;
    endfunction

    task automatic drive(input logic st, input logic mr, input logic [31:0] ir, input vec_t e);
        @(posedge clk);
        #1;
        stall   = st;
        mem_rdy = mr;
        IR      = ir;
        exp_q.push_back(e);
    endtask

    task automatic reset_seq(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            clr = 1'b1;
            stall = 1'($urandom_range(0, 1));
            exp_q.push_back(idle());
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        stall = 1'($urandom_range(0, 1));
        exp_q.push_back(idle());
    endtask

    // Expand one instruction into its per-cycle expectations, then play it out.
    task automatic run_instr(input logic [31:0] ir, input int w, input int st_idx,
                             input int st_n, input bit rnd, input int clr_idx);
        vec_t        seq[$];
        bit          mr[$];
        bit          use_ir[$];
        vec_t        v;
        logic [4:0]  op;
        logic [3:0]  ra, rb, rc;
        logic [31:0] ir_v;
        int          k;
        int          ns;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        k  = op_kind(op);
        v = idle(); v.pcout = 1'b1; v.marin = 1'b1; v.zin = 1'b1; v.opcode = 5'd12;
        seq.push_back(v); mr.push_back(1'($urandom_range(0, 1))); use_ir.push_back(1'b0);
        v = idle(); v.zlowout = 1'b1; v.pcin = 1'b1; v.read = 1'b1; v.mdrin = 1'b1;
        seq.push_back(v); mr.push_back(w == 0); use_ir.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            v = idle(); v.read = 1'b1; v.mdrin = 1'b1;
            seq.push_back(v); mr.push_back(i == w - 1); use_ir.push_back(1'b0);
        end
        v = idle(); v.mdrout = 1'b1; v.irin = 1'b1; v.done = (k == 0);
        seq.push_back(v);
        if (k == 1) begin
            v = idle(); v.rout = oh(rb); v.yin = 1'b1; seq.push_back(v);
            v = idle(); v.rout = oh(rc); v.zin = 1'b1; v.opcode = op; seq.push_back(v);
            v = idle(); v.zlowout = 1'b1; v.rin = oh(ra); v.done = 1'b1; seq.push_back(v);
        end else if (k == 2) begin
            v = idle(); v.rout = oh(ra); v.yin = 1'b1; seq.push_back(v);
            v = idle(); v.rout = oh(rb); v.zin = 1'b1; v.opcode = op; seq.push_back(v);
            v = idle(); v.zlowout = 1'b1; v.loin = 1'b1; seq.push_back(v);
            v = idle(); v.zhighout = 1'b1; v.hiin = 1'b1; v.done = 1'b1; seq.push_back(v);
        end else if (k == 3) begin
            v = idle(); v.rout = oh(rb); v.zin = 1'b1; v.opcode = op; seq.push_back(v);
            v = idle(); v.zlowout = 1'b1; v.rin = oh(ra); v.done = 1'b1; seq.push_back(v);
        end
        while (mr.size() < seq.size()) begin
            mr.push_back(1'($urandom_range(0, 1)));
            use_ir.push_back(1'b1);
        end
        for (int s = 0; s < seq.size(); s++) begin
            ir_v = use_ir[s] ? ir : $urandom();
            if (s == clr_idx) begin
                @(posedge clk);
                #1;
                stall = 1'b0; mem_rdy = mr[s]; IR = ir_v;
                exp_q.push_back(idle());
                #2 clr = 1'b1;
                #1;
                checks++;
                if (act !== idle()) begin
                    errors++;
                    $display("FAIL clr_async got=%h expected=%h", act, idle());
                end
                return;
            end
            if (s == st_idx) ns = st_n;
            else if (rnd && $urandom_range(0, 3) == 0) ns = $urandom_range(1, 2);
            else ns = 0;
            for (int n = 0; n < ns; n++) begin
                drive(1'b1, 1'($urandom_range(0, 1)), ir_v, idle());
            end
            drive(1'b0, mr[s], ir_v, seq[s]);
        end
        if (k == 4) begin
            v = '0;
            for (int i = 0; i < 20; i++) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir, v);
            end
        end
    endtask

    logic [4:0]  legal_ops [0:12];
    logic [4:0]  rop;
    logic [31:0] rbits;
    logic [31:0] add_ir;

    initial begin
        legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                      5'd15, 5'd16, 5'd17, 5'd18};
        add_ir  = {5'd3, 4'd4, 4'd5, 4'd6, 15'd0};
        clr     = 1'b1;
        stall   = 1'b0;
        mem_rdy = 1'b0;
        IR      = 32'd0;
        reset_seq(3);

        run_instr(32'h28918000, 0, -1, 0, 1'b0, -1);
        run_instr(add_ir, 3, -1, 0, 1'b0, -1);
        run_instr({5'd15, 4'd6, 4'd7, 4'd0, 15'd0}, 0, -1, 0, 1'b0, -1);
        run_instr(add_ir, 0, 4, 2, 1'b0, -1);
        run_instr({5'd17, 4'd9, 4'd12, 4'd0, 15'd0}, 1, -1, 0, 1'b0, -1);
        run_instr({5'd31, 27'd0}, 0, -1, 0, 1'b0, -1);
        run_instr(32'h28918000, 0, 1, 2, 1'b0, -1);
        run_instr(add_ir, 0, -1, 0, 1'b0, 4);
        reset_seq(1);

        for (int t = 0; t < 60; t++) begin
            rbits = $urandom();
            if ($urandom_range(0, 1) == 0) rop = legal_ops[$urandom_range(0, 12)];
            else rop = 5'($urandom_range(0, 31));
            if (rop == 5'd26) rop = 5'd0;
            if ($urandom_range(0, 11) == 0) begin
                run_instr({rop, rbits[26:0]}, $urandom_range(0, 3), -1, 0, 1'b1,
                          $urandom_range(0, 2));
                reset_seq($urandom_range(1, 2));
            end else begin
                run_instr({rop, rbits[26:0]}, $urandom_range(0, 3), -1, 0, 1'b1, -1);
            end
        end

        run_instr({5'd26, 27'd0}, 1, -1, 0, 1'b1, -1);
        reset_seq(2);
        run_instr(32'h28918000, 0, -1, 0, 1'b1, -1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore-style control unit that drives the datapath control inputs.
- Handles the fetch (T0-T2) and execute (T3-T6) phases that benches currently hand-sequence.
- Sits beside Datapath: consumes the instruction-register word and a memory-ready strobe; produces every bus-out/load-enable, the ALU OpCode, and one-hot register selects.

Parameters:
- PC_INC_OP, 5'd12, ALU OpCode used in T0 to form PC+1 in Z.
- NUM_REGS, 16, number of general registers; width of Rin/Rout.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-high reset
- IR  in  32  instruction register contents from datapath
- mem_rdy  in  1  memory read data valid on Mdatain
- stall  in  1  freeze sequencer this cycle
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive enables
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables
- Read  out  1  memory read request
- OpCode  out  5  ALU operation select
- Rin  out  16  one-hot GPR load enable
- Rout  out  16  one-hot GPR bus drive
- run  out  1  high unless halted
- done  out  1  one-cycle pulse in final execute cycle of each instruction

Behaviour:
- Interface is fixed: one clock, clk; reset clr is asynchronous and active-high.
- IR fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
- Opcodes:
  - binary: add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11
  - mul 15, div 16
  - unary: neg 17, not 18
  - halt 26
  - all others illegal and treated as NOP
- States: RST, T0, T1, T1W, T2, T3, T4, T5, T6, HALT. State is registered. Outputs decode combinationally from state and IR. Every output not listed for a state is 0.
- clr high (any time, including mid-instruction): state goes to RST immediately; all outputs 0; run=1.
- RST: next state is T0.
- T0: PCout, MARin, Zin; OpCode=PC_INC_OP.
- T1: Zlowout, PCin, Read, MDRin. Next state is T2 if mem_rdy, else T1W.
- T1W: Read, MDRin only; PCin is never repeated. Stays in T1W until mem_rdy, then goes to T2.
- T2: MDRout, IRin. Next state by op:
  - binary, mul, div, unary: T3
  - halt: HALT
  - illegal: T0, with done pulsed in T2
- Binary ops (6 cycles when mem_rdy=1 in T1):
  - T3: Rout[rb], Yin
  - T4: Rout[rc], Zin, OpCode=op
  - T5: Zlowout, Rin[ra], done; next state T0
- mul/div (7 cycles):
  - T3: Rout[ra], Yin
  - T4: Rout[rb], Zin, OpCode=op
  - T5: Zlowout, LOin
  - T6: Zhighout, HIin, done; next state T0
- Unary ops (5 cycles):
  - T3: Rout[rb], Zin, OpCode=op
  - T4: Zlowout, Rin[ra], done; next state T0
- OpCode is 0 in every state except T0 and the Zin cycle of execute.
- HALT: run=0, all other outputs 0. HALT is terminal; only clr exits.
- stall=1: state register holds and all outputs are forced 0, including done. Resumes the same state when stall drops. stall is ignored in RST and HALT.
- stall and mem_rdy both high in T1: stall wins; mem_rdy is re-sampled on the resumed cycle.
- Rin/Rout are always one-hot or zero. A field selecting a register index of NUM_REGS or above yields zero.
- IR must remain stable from T3 until the instruction ends; the block does not latch it.

Decomposition:
- Package cpu_ctrl_pkg: opcode localparams, state encoding, IR field bit positions.
- Sub-module reg_select_decoder: 4-bit index plus enable to NUM_REGS-wide one-hot vector.
  - Instantiated twice: one for Rin, one for Rout.
  - The sequencer supplies the index (ra/rb/rc) and enable per state.

Test Plan:
- and R1,R2,R3 (IR=0x28918000), mem_rdy=1 -> exact per-cycle trace:
  - T0: PCout, MARin, Zin, OpCode=12
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
  - T3: Rout=0x0004, Yin
  - T4: Rout=0x0008, Zin, OpCode=5
  - T5: Zlowout, Rin=0x0002, done
  - next cycle is T0
- mem_rdy low for 3 cycles after T1 -> three T1W cycles with Read=MDRin=1 and PCin=0; T2 follows the cycle mem_rdy rises; PCin high exactly once.
- mul R6,R7 (op 15, ra=6, rb=7) -> T3 Rout=0x0040 Yin; T4 Rout=0x0080 OpCode=15; T5 Zlowout LOin; T6 Zhighout HIin done.
- stall=1 for 2 cycles during T4 of add -> outputs all 0 for 2 cycles, then T4 signals reappear once, then T5; done pulses exactly once.
- clr asserted mid-T4, asynchronously between edges -> outputs 0 within the same cycle; after clr release: RST, then T0.
- halt (op 26) fetched -> after T2, run=0 and all outputs stay 0 for 20 cycles; illegal op 31 -> done pulses in T2, then T0.
